// File: rtl/frame_decoder_rx.sv
// Receive-path byte de-stuffer: hunts for START, removes ESCAPE stuffing, strips
// delimiters and emits frame payload as a byte stream with tlast on the final byte.
module frame_decoder_rx #(
  parameter logic [7:0] ESCAPE_BYTE = 8'h7F,
  parameter logic [7:0] START_BYTE  = 8'h7D,
  parameter logic [7:0] STOP_BYTE   = 8'h7E
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        rx_byte_tvalid,
  output logic        rx_byte_tready,
  input  logic [7:0]  rx_byte_tdata,
  output logic        rx_frame_tvalid,
  input  logic        rx_frame_tready,
  output logic [7:0]  rx_frame_tdata,
  output logic        rx_frame_tlast,
  output logic        frame_error,
  output logic [15:0] err_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_IN_FRAME = 2'd1,
    S_ESCAPED  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;

  logic        hold_valid;
  logic [7:0]  hold_data;
  logic        hold_valid_nxt;
  logic [7:0]  hold_data_nxt;

  logic        consume;
  logic        is_start;
  logic        is_stop;
  logic        is_esc;
  logic        take_data;
  logic        emit;
  logic        emit_last;
  logic        abort;

  // Handshake: a transfer happens on a channel at a rising edge where both
  // tvalid and tready are high; a source holds tdata/tlast stable while
  // tvalid && !tready. An input byte is accepted only when the output register
  // is free or draining this cycle, so each accepted byte loads it at most once.
  assign rx_byte_tready = aresetn && (!out_valid || rx_frame_tready);
  assign consume        = rx_byte_tvalid && rx_byte_tready;

  assign is_start = (rx_byte_tdata == START_BYTE);
  assign is_stop  = (rx_byte_tdata == STOP_BYTE);
  assign is_esc   = (rx_byte_tdata == ESCAPE_BYTE);

  always_comb begin
    state_nxt      = state;
    hold_valid_nxt = hold_valid;
    hold_data_nxt  = hold_data;
    take_data      = 1'b0;
    emit           = 1'b0;
    emit_last      = 1'b0;
    abort          = 1'b0;

    if (consume) begin
      case (state)
        S_IDLE: begin
          if (is_start) begin
            state_nxt      = S_IN_FRAME;
            hold_valid_nxt = 1'b0;
          end
        end
        S_IN_FRAME: begin
          if (is_esc) begin
            state_nxt = S_ESCAPED;
          end else if (is_stop) begin
            // An empty frame leaves nothing in hold, so nothing is emitted.
            emit           = hold_valid;
            emit_last      = 1'b1;
            hold_valid_nxt = 1'b0;
            state_nxt      = S_IDLE;
          end else if (is_start) begin
            // START mid-frame closes the partial frame and opens a new one.
            emit           = hold_valid;
            emit_last      = 1'b1;
            abort          = hold_valid;
            hold_valid_nxt = 1'b0;
          end else begin
            take_data = 1'b1;
          end
        end
        S_ESCAPED: begin
          take_data = 1'b1;
          state_nxt = S_IN_FRAME;
        end
        default: begin
          state_nxt      = S_IDLE;
          hold_valid_nxt = 1'b0;
        end
      endcase
    end

    // The hold register gives one byte of lookahead, so the previous byte is
    // only released once we know it is not the last of its frame.
    if (take_data) begin
      emit           = hold_valid;
      emit_last      = 1'b0;
      hold_data_nxt  = rx_byte_tdata;
      hold_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      hold_valid  <= 1'b0;
      hold_data   <= 8'h00;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      out_last    <= 1'b0;
      frame_error <= 1'b0;
      err_count   <= 16'h0000;
    end else begin
      state      <= state_nxt;
      hold_valid <= hold_valid_nxt;
      hold_data  <= hold_data_nxt;

      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= hold_data;
        out_last  <= emit_last;
      end else if (rx_frame_tready) begin
        out_valid <= 1'b0;
      end

      frame_error <= abort;
      if (abort && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

  assign rx_frame_tvalid = out_valid;
  assign rx_frame_tdata  = out_data;
  assign rx_frame_tlast  = out_last;
  assign dbg_state       = state;

endmodule

// File: tb/tb_frame_decoder_rx.sv
// Bench for frame_decoder_rx: directed frames plus random streams checked against
// a frame-level reference model that flushes whole payloads at each delimiter.
module tb_frame_decoder_rx;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        rx_byte_tvalid = 1'b0;
  logic        rx_byte_tready;
  logic [7:0]  rx_byte_tdata = 8'h00;
  logic        rx_frame_tvalid;
  logic        rx_frame_tready = 1'b1;
  logic [7:0]  rx_frame_tdata;
  logic        rx_frame_tlast;
  logic        frame_error;
  logic [15:0] err_count;
  logic [1:0]  dbg_state;

  frame_decoder_rx dut (
    .aclk            (clk),
    .aresetn         (aresetn),
    .rx_byte_tvalid  (rx_byte_tvalid),
    .rx_byte_tready  (rx_byte_tready),
    .rx_byte_tdata   (rx_byte_tdata),
    .rx_frame_tvalid (rx_frame_tvalid),
    .rx_frame_tready (rx_frame_tready),
    .rx_frame_tdata  (rx_frame_tdata),
    .rx_frame_tlast  (rx_frame_tlast),
    .frame_error     (frame_error),
    .err_count       (err_count),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / model state ----------------
  logic [7:0] tx_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [8:0] plan_q[$];
  logic [7:0] payload[$];
  bit         m_in_frame = 0;
  bit         m_esc = 0;
  int         m_err = 0;
  int         err_seen = 0;

  bit         gap_en = 0;
  int         rdy_mode = 0;
  int         rdy_cnt = 0;
  bit         byte_taken = 0;
  bit         prev_stall = 0;
  logic [8:0] stall_beat = '0;

  task automatic flush_payload();
    for (int i = 0; i < payload.size(); i++)
      exp_q.push_back({(i == payload.size() - 1), payload[i]});
    payload.delete();
  endtask

  // Frame-level view: collect a whole payload, release it at STOP or at an aborting START.
  task automatic model_byte(input logic [7:0] b);
    if (!m_in_frame) begin
      if (b == 8'h7D) begin
        m_in_frame = 1;
        payload.delete();
      end
    end else if (m_esc) begin
      payload.push_back(b);
      m_esc = 0;
    end else if (b == 8'h7F) begin
      m_esc = 1;
    end else if (b == 8'h7E) begin
      flush_payload();
      m_in_frame = 0;
    end else if (b == 8'h7D) begin
      if (payload.size() > 0) m_err++;
      flush_payload();
    end else begin
      payload.push_back(b);
    end
  endtask

  task automatic reset_model();
    m_in_frame = 0;
    m_esc = 0;
    m_err = 0;
    err_seen = 0;
    payload.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- driver ----------------
  always @(posedge clk) begin
    #1;
    if (!(rx_byte_tvalid && !byte_taken)) begin
      if (tx_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
        rx_byte_tvalid = 1'b1;
        rx_byte_tdata  = tx_q[0];
      end else begin
        rx_byte_tvalid = 1'b0;
      end
    end
    byte_taken = 0;
    case (rdy_mode)
      0: rx_frame_tready = 1'b1;
      1: begin
        rx_frame_tready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
        rdy_cnt++;
      end
      default: rx_frame_tready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!aresetn) begin
      prev_stall = 0;
    end else begin
      check_eq("byte_tready_rule", rx_byte_tready, !(rx_frame_tvalid && !rx_frame_tready));
      if (prev_stall) begin
        check_eq("stall_tvalid", rx_frame_tvalid, 1);
        check_eq("stall_beat", {rx_frame_tlast, rx_frame_tdata}, stall_beat);
      end
      prev_stall = rx_frame_tvalid && !rx_frame_tready;
      stall_beat = {rx_frame_tlast, rx_frame_tdata};
      if (rx_frame_tvalid && rx_frame_tready) got_q.push_back({rx_frame_tlast, rx_frame_tdata});
      if (frame_error) err_seen++;
      if (rx_byte_tvalid && rx_byte_tready) begin
        model_byte(tx_q.pop_front());
        byte_taken = 1;
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic drain(input string name);
    int n = 0;
    while ((tx_q.size() != 0 || rx_byte_tvalid || rx_frame_tvalid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq({name, "_drain_timeout"}, (n >= 2000), 0);
  endtask

  task automatic run_seg(input string name);
    drain(name);
    check_eq({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq({name, "_beat"}, got_q[i], exp_q[i]);
    if (plan_q.size() > 0) begin
      check_eq({name, "_plan_count"}, got_q.size(), plan_q.size());
      for (int i = 0; i < got_q.size() && i < plan_q.size(); i++)
        check_eq({name, "_plan_beat"}, got_q[i], plan_q[i]);
    end
    check_eq({name, "_err_count"}, err_count, m_err);
    check_eq({name, "_err_pulses"}, err_seen, m_err);
    got_q.delete();
    exp_q.delete();
    plan_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_tvalid"}, rx_frame_tvalid, 0);
    check_eq({name, "_tdata"}, rx_frame_tdata, 0);
    check_eq({name, "_tlast"}, rx_frame_tlast, 0);
    check_eq({name, "_frame_error"}, frame_error, 0);
    check_eq({name, "_err_count"}, err_count, 0);
    check_eq({name, "_byte_tready"}, rx_byte_tready, 0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #2 aresetn = 1'b0;
    @(negedge clk);
    check_reset_outputs(name);
    #2 aresetn = 1'b1;
    reset_model();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int err_before;
    logic [7:0] b;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    #2 aresetn = 1'b1;

    tx_q   = '{8'h7D, 8'h11, 8'h22, 8'h33, 8'h7E};
    plan_q = '{9'h011, 9'h022, 9'h133};
    run_seg("basic");

    tx_q   = '{8'h7D, 8'h7F, 8'h7E, 8'h7F, 8'h7D, 8'h7F, 8'h7F, 8'h44, 8'h7E};
    plan_q = '{9'h07E, 9'h07D, 9'h07F, 9'h144};
    run_seg("escaped");

    tx_q   = '{8'h55, 8'h66, 8'h7D, 8'h7E, 8'h7D, 8'hAA, 8'h7E};
    plan_q = '{9'h1AA};
    run_seg("garbage_empty");

    err_before = err_count;
    tx_q   = '{8'h7D, 8'h01, 8'h02, 8'h7D, 8'h03, 8'h7E};
    plan_q = '{9'h001, 9'h102, 9'h103};
    run_seg("abort");
    check_eq("abort_err_incr", err_count - err_before, 1);

    rdy_mode = 1;
    tx_q   = '{8'h7D, 8'h11, 8'h22, 8'h33, 8'h7E};
    plan_q = '{9'h011, 9'h022, 9'h133};
    run_seg("backpressure");
    rdy_mode = 0;

    tx_q = '{8'h7D, 8'h11, 8'h22};
    drain("reset_pre");
    check_eq("reset_pre_count", got_q.size(), 1);
    if (got_q.size() > 0) check_eq("reset_pre_beat", got_q[0], 9'h011);
    do_reset("reset_mid");
    tx_q   = '{8'h33, 8'h7E, 8'h7D, 8'h44, 8'h7E};
    plan_q = '{9'h144};
    run_seg("reset_after");

    // Random streams with special bytes biased in, input gaps and random output stalls.
    gap_en   = 1;
    rdy_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int f = 0; f < 12; f++) begin
        if ($urandom_range(0, 3) == 0) tx_q.push_back(8'($urandom_range(0, 255)));
        tx_q.push_back(8'h7D);
        for (int k = 0; k < $urandom_range(0, 7); k++) begin
          case ($urandom_range(0, 7))
            0: b = 8'h7D;
            1: b = 8'h7E;
            2: b = 8'h7F;
            default: b = 8'($urandom_range(0, 255));
          endcase
          tx_q.push_back(b);
        end
        if ($urandom_range(0, 4) != 0) tx_q.push_back(8'h7E);
      end
      tx_q.push_back(8'h7E);
      tx_q.push_back(8'h7E);
      run_seg("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_decoder_rx.md
Name: frame_decoder_rx

Overview:
- Receive-path byte de-stuffer. Sits between the UART byte receiver and the destination packetizer.
- Consumes the raw AXI4-Stream byte stream, hunts for START, removes ESCAPE stuffing and strips START/STOP delimiters.
- Emits frame payload as an AXI4-Stream with tlast asserted on the final payload byte.
- A one-byte hold register supplies the lookahead needed to place tlast without stalling.

Parameters:
ESCAPE_BYTE  8'h7F  next byte taken literally
START_BYTE   8'h7D  frame start delimiter
STOP_BYTE    8'h7E  frame stop delimiter

Ports:
aclk             in   1   clock, all logic on rising edge
aresetn          in   1   synchronous active-low reset
rx_byte_tvalid   in   1   raw byte valid
rx_byte_tready   out  1   raw byte accept
rx_byte_tdata    in   8   raw byte
rx_frame_tvalid  out  1   payload byte valid
rx_frame_tready  in   1   downstream accept
rx_frame_tdata   out  8   payload byte
rx_frame_tlast   out  1   last payload byte of frame
frame_error      out  1   one-cycle pulse: frame aborted by START
err_count        out  16  saturating count of frame_error pulses

Behaviour:
- Reset: aresetn low at a rising edge clears all outputs and state.
  - rx_frame_tvalid=0, tdata=0, tlast=0, frame_error=0, err_count=0.
  - hold_valid=0, state=IDLE. Any frame in progress is discarded.
  - rx_byte_tready=0 while aresetn=0.
- Storage: output register {out_valid, out_data, out_last}, which drives the rx_frame_* ports, plus hold register {hold_valid, hold_data}.
- Handshake:
  - rx_byte_tready = !out_valid || rx_frame_tready. Every consumed byte loads the output register at most once.
  - out_valid clears on rx_frame_tvalid && rx_frame_tready unless reloaded the same cycle.
  - tdata/tlast are held stable while tvalid && !tready.
  - Sustained throughput is 1 byte/cycle.
- Byte consumed = rx_byte_tvalid && rx_byte_tready.
- States:
  - IDLE:
    - START -> IN_FRAME, hold_valid=0.
    - Any other byte is discarded.
  - IN_FRAME:
    - ESCAPE -> ESCAPED. Nothing stored.
    - STOP, hold_valid=1: out <= {hold_data, last=1}, hold_valid=0, -> IDLE.
    - STOP, hold_valid=0: empty frame, dropped silently, -> IDLE.
    - START, hold_valid=1: out <= {hold_data, last=1}, frame_error pulse, hold_valid=0, stay IN_FRAME (new frame begins).
    - START, hold_valid=0: new frame begins, no error.
    - Other data byte D, hold_valid=1: out <= {hold_data, last=0}, hold_data <= D.
    - Other data byte D, hold_valid=0: hold_data <= D, hold_valid=1, no output.
  - ESCAPED:
    - Any byte, including START/STOP/ESCAPE, is treated as a literal data byte D (same rule as IN_FRAME data) -> IN_FRAME. No XOR applied.
- Latency: the first payload byte appears one cycle after the second payload byte (or STOP) is consumed. The final byte appears one cycle after STOP is consumed.
- err_count: increments on each frame_error pulse and saturates at 16'hFFFF.
- Output stall: while rx_frame_tready=0 and out_valid=1, no byte is consumed. Hold and state are frozen.

Test Plan:
- Basic frame: bytes 7D 11 22 33 7E, tready=1.
  - -> payload 11, 22, 33 with tlast only on 33.
  - -> 3 beats, frame_error never asserts.
- Escaped delimiters: 7D 7F 7E 7F 7D 7F 7F 44 7E.
  - -> payload 7E, 7D, 7F, 44, tlast on 44.
- Leading garbage and empty frame: 55 66 7D 7E 7D AA 7E.
  - -> single beat AA, tlast=1.
  - -> garbage and empty frame produce no output.
- Abort: 7D 01 02 7D 03 7E.
  - -> payload 01, 02(tlast); frame_error pulses once, err_count=1.
  - -> then 03(tlast).
- Backpressure: basic frame with rx_frame_tready toggling 1,0,0,1 repeating.
  - -> output data 11, 22, 33 unchanged, no byte lost or duplicated.
  - -> rx_byte_tready low whenever out_valid && !rx_frame_tready.
- Reset mid-frame: after 7D 11 22, assert aresetn=0 for one cycle, then send 33 7E 7D 44 7E.
  - -> outputs zero during reset.
  - -> only 44(tlast) emitted afterwards.
